prog_loader: RTL and testbench

// - Upstream stage of the program memory: takes a byte stream (UART RX or debug bridge) and writes instruction words via pgm/addr/data.
// - Assembles STEP bytes little-endian per word, writes words consecutively from address 0, holds the core while loading.
// - Lets a new program be loaded without resynthesis or a $readmemh image.

---
 rtl/prog_loader_pkg.sv | 44 ++++
 rtl/word_packer.sv | 72 +++++++
 rtl/prog_loader.sv | 217 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader:
//   - default parameter values (word address width, bytes per word)
//   - loader state encoding (3 bits)
//   - helpers that classify states and check the requested word count
//     against the program memory capacity
// Optional feature switch used by the loader RTL: PROG_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    localparam int DEF_INSTR_ADDR_WIDTH = 20;
    localparam int DEF_STEP             = 4;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LEN0  = 3'd1,
        LDR_LEN1  = 3'd2,
        LDR_DATA  = 3'd3,
        LDR_WRITE = 3'd4,
        LDR_CSUM  = 3'd5,
        LDR_DONE  = 3'd6,
        LDR_ERR   = 3'd7
    } ldr_state_e;

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_bytes(input ldr_state_e s);
        return (s == LDR_LEN0) || (s == LDR_LEN1) || (s == LDR_DATA) || (s == LDR_CSUM);
    endfunction

    // States in which the core must be held off the program memory.
    function automatic logic is_busy(input ldr_state_e s);
        return (s != LDR_IDLE) && (s != LDR_DONE) && (s != LDR_ERR);
    endfunction

    // A word count equal to the capacity is legal; only strictly larger fails.
    // The compare is done at 33 bits so any address width up to 32 is safe.
    function automatic logic exceeds_capacity(input logic [15:0] n, input int unsigned aw);
        logic [32:0] cap;
        cap = 33'd1 << aw;
        return {17'd0, n} > cap;
    endfunction

endpackage

// File: rtl/word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Assembles STEP bytes into one little-endian word: the first byte of a word
// lands in bits [7:0]. Keeps its own byte counter and wraps after each full
// word, so consecutive words need no explicit clear.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          drop any partially assembled word (session start / abort)
//   byte_en      byte_in is taken this cycle
//   byte_in      stream byte
//   word_full    byte_en and this byte completes the word (combinational)
//   word_next    word including byte_in; valid as a full word when word_full
// -----------------------------------------------------------------------------
module word_packer
    import prog_loader_pkg::*;
#(
    parameter int STEP = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic              word_full,
    output logic [STEP*8-1:0] word_next
);

    localparam int W  = STEP * 8;
    localparam int CW = $clog2(STEP + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  word_q, word_d;

    // Bytes enter at the top and shift down, so after STEP bytes the first
    // one has reached the least significant lane.
    generate
        if (STEP == 1) begin : g_single
            assign word_next = byte_in;
        end else begin : g_shift
            assign word_next = {byte_in, word_q[W-1:8]};
        end
    endgenerate

    assign word_full = byte_en && (cnt_q == CW'(STEP - 1));

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_en) begin
            word_d = word_next;
            cnt_d  = word_full ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a byte stream framed as LEN_LO, LEN_HI (16-bit word count N) and
// N*STEP data bytes, and writes the words consecutively from address 0 into
// the program memory through pgm/addr/data. The core is held while a session
// is in progress.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the 8-bit modulo sum of all data bytes before signalling done.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_start            pulse, starts a session from IDLE/DONE/ERR
//   load_abort            pulse, abandons any session (highest priority)
//   rx_data/rx_valid      stream byte and its valid
//   rx_ready              loader accepts a byte this cycle
//   pgm/addr/data         one-cycle memory write strobe, word address, word
//   cpu_hold              session in progress, core must not fetch
//   done                  one-cycle pulse on successful completion
//   error                 level, high while in the error state
// All outputs are registered.
// -----------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH = DEF_INSTR_ADDR_WIDTH,
    parameter int STEP             = DEF_STEP
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_start,
    input  logic                        load_abort,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    output logic                        pgm,
    output logic [INSTR_ADDR_WIDTH-1:0] addr,
    output logic [STEP*8-1:0]           data,
    output logic                        cpu_hold,
    output logic                        done,
    output logic                        error
);

    localparam int W  = STEP * 8;
    localparam int AW = INSTR_ADDR_WIDTH;

    ldr_state_e     state_q, state_d;
    logic [15:0]    len_q, len_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [W-1:0]   data_q, data_d;
    logic           rx_ready_q, rx_ready_d;
    logic           pgm_q, pgm_d;
    logic           cpu_hold_q, cpu_hold_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]     sum_q, sum_d;
`endif

    logic           rx_fire;
    logic           pack_clr;
    logic           pack_en;
    logic           pack_full;
    logic [W-1:0]   pack_word;
    logic [15:0]    len_rx;

    // rx_ready is a flop that already reflects the current state, so a
    // transfer is simply valid meeting ready.
    assign rx_fire = rx_valid && rx_ready_q;
    assign len_rx  = {rx_data, len_q[7:0]};

    word_packer #(
        .STEP (STEP)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pack_clr),
        .byte_en   (pack_en),
        .byte_in   (rx_data),
        .word_full (pack_full),
        .word_next (pack_word)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        pack_clr = 1'b0;
        pack_en  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif

        if (load_abort) begin
            // Words already written stay in memory; only the partial word goes.
            state_d  = LDR_IDLE;
            pack_clr = 1'b1;
        end else begin
            unique case (state_q)
                LDR_IDLE, LDR_DONE, LDR_ERR: begin
                    if (load_start) begin
                        state_d  = LDR_LEN0;
                        addr_d   = '0;
                        cnt_d    = '0;
                        pack_clr = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d    = '0;
`endif
                    end
                end
                LDR_LEN0: begin
                    if (rx_fire) begin
                        len_d   = {8'd0, rx_data};
                        state_d = LDR_LEN1;
                    end
                end
                LDR_LEN1: begin
                    if (rx_fire) begin
                        len_d = len_rx;
                        if (len_rx == 16'd0) begin
                            state_d = LDR_DONE;
                        end else if (exceeds_capacity(len_rx, AW)) begin
                            state_d = LDR_ERR;
                        end else begin
                            state_d = LDR_DATA;
                        end
                    end
                end
                LDR_DATA: begin
                    if (rx_fire) begin
                        pack_en = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + rx_data;
`endif
                        if (pack_full) begin
                            data_d  = pack_word;
                            state_d = LDR_WRITE;
                        end
                    end
                end
                LDR_WRITE: begin
                    cnt_d = cnt_q + 16'd1;
                    if ((cnt_q + 16'd1) == len_q) begin
                        // Address is left on the last word so a full-capacity
                        // load never wraps it back to 0.
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = LDR_CSUM;
`else
                        state_d = LDR_DONE;
`endif
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = LDR_DATA;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                LDR_CSUM: begin
                    if (rx_fire) begin
                        state_d = (rx_data == sum_q) ? LDR_DONE : LDR_ERR;
                    end
                end
`endif
                default: state_d = LDR_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with
        // the state they describe.
        rx_ready_d = accepts_bytes(state_d);
        pgm_d      = (state_d == LDR_WRITE);
        cpu_hold_d = is_busy(state_d);
        error_d    = (state_d == LDR_ERR);
        done_d     = (state_d == LDR_DONE) && (state_q != LDR_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LDR_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rx_ready_q <= 1'b0;
            pgm_q      <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rx_ready_q <= rx_ready_d;
            pgm_q      <= pgm_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign rx_ready = rx_ready_q;
    assign pgm      = pgm_q;
    assign addr     = addr_q;
    assign data     = data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader with STEP=4, INSTR_ADDR_WIDTH=5.
// Expected memory writes are derived from the frame contents (word i at
// address i), expected done/error from the word count and capacity.
// Honours PROG_LOADER_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int AW   = 5;
    localparam int STEP = 4;
    localparam int W    = STEP * 8;
    localparam int CAP  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          load_abort = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          pgm;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          cpu_hold;
    logic          done;
    logic          error;

    prog_loader #(
        .INSTR_ADDR_WIDTH (AW),
        .STEP             (STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_abort (load_abort),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .pgm        (pgm),
        .addr       (addr),
        .data       (data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_base;

    logic [7:0]      frame_q[$];
    logic [AW+W-1:0] exp_wr[$];
    logic [AW+W-1:0] obs_wr[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory-side observer: records every write and counts done cycles.
    always @(negedge clk) begin
        if (rst_n && pgm) begin
            obs_wr.push_back({addr, data});
            check("rx_ready_low_in_write", {63'd0, rx_ready}, 64'd0);
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic mark();
        done_base = done_cnt;
        obs_wr.delete();
        exp_wr.delete();
        frame_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_valid   = 1'b0;
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        rx_valid   = 1'b0;
        load_abort = 1'b1;
        @(posedge clk);
        #1 load_abort = 1'b0;
    endtask

    // Presents one byte until it is accepted; with toggle set, valid is
    // dropped on every other cycle.
    task automatic send_byte(input logic [7:0] b, input bit toggle);
        bit skip = 1'b0;
        bit ok;
        int guard = 0;
        forever begin
            @(negedge clk);
            ok = 1'b0;
            if (toggle && skip) begin
                rx_valid = 1'b0;
                skip     = 1'b0;
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
                ok       = rx_ready;
                skip     = 1'b1;
            end
            @(posedge clk);
            if (ok) break;
            guard++;
            if (guard > 200) begin
                failures++;
                $error("FAIL send_timeout observed=not_accepted expected=accepted byte=0x%0h", b);
                break;
            end
        end
    endtask

    task automatic idle_rx();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends frame_q; start_at >= 0 inserts a load_start before that byte.
    task automatic send_frame(input bit toggle, input int start_at);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(frame_q[i], toggle);
        end
        idle_rx();
    endtask

    // Random frame of n words; length bytes always, data only when legal.
    task automatic build_random(input int n, input bit bad_csum);
        logic [W-1:0] w;
        logic [7:0]   sum = 8'd0;
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        if (n > CAP) return;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_wr.push_back({AW'(i), w});
            for (int k = 0; k < STEP; k++) begin
                frame_q.push_back(w[8*k +: 8]);
                sum = sum + w[8*k +: 8];
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (n > 0) frame_q.push_back(bad_csum ? sum + 8'd1 : sum);
`else
        if (bad_csum) frame_q.push_back(8'd0);
`endif
    endtask

    task automatic compare(input string tag, input int exp_done, input bit exp_err);
        repeat (6) @(negedge clk);
        check({tag, "_nwrites"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(obs_wr[i]), 64'(exp_wr[i]));
        check({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'(exp_done));
        check({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
        check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pgm"}, {63'd0, pgm}, 64'd0);
        check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd0);
        check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_error"}, {63'd0, error}, 64'd0);
        check({tag, "_addr"}, 64'(addr), 64'd0);
        check({tag, "_data"}, 64'(data), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed two-word program
        mark();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef PROG_LOADER_CHECKSUM_EN
        frame_q.push_back(8'hB6);
`endif
        exp_wr.push_back({5'd0, 32'h0000_0013});
        exp_wr.push_back({5'd1, 32'h0010_0093});
        pulse_start();
        check("start_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        check("start_rx_ready", {63'd0, rx_ready}, 64'd1);
        send_frame(1'b0, -1);
        compare("normal", 1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Wrong checksum: both words written, then error
        mark();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        exp_wr.push_back({5'd0, 32'h0000_0013});
        exp_wr.push_back({5'd1, 32'h0010_0093});
        pulse_start();
        send_frame(1'b0, -1);
        compare("bad_csum", 0, 1'b1);
`endif

        // Empty program
        mark();
        build_random(0, 1'b0);
        pulse_start();
        send_frame(1'b0, -1);
        compare("empty", 1, 1'b0);

        // One word over capacity
        mark();
        build_random(CAP + 1, 1'b0);
        pulse_start();
        send_frame(1'b0, -1);
        compare("overflow", 0, 1'b1);
        check("overflow_rx_ready", {63'd0, rx_ready}, 64'd0);

        // Exactly full capacity, starting from the error state
        mark();
        build_random(CAP, 1'b0);
        pulse_start();
        check("restart_clears_error", {63'd0, error}, 64'd0);
        send_frame(1'b0, -1);
        compare("full", 1, 1'b0);

        // Backpressure: valid toggling every cycle
        mark();
        build_random(3, 1'b0);
        pulse_start();
        send_frame(1'b1, -1);
        compare("backpressure", 1, 1'b0);

        // load_start mid-word is ignored
        mark();
        build_random(2, 1'b0);
        pulse_start();
        send_frame(1'b0, 4);
        compare("busy_start", 1, 1'b0);

        // Abort after two bytes of word 1
        mark();
        build_random(2, 1'b0);
        void'(exp_wr.pop_back());
        pulse_start();
        for (int i = 0; i < 2 + STEP + 2; i++) send_byte(frame_q[i], 1'b0);
        pulse_abort();
        compare("abort", 0, 1'b0);
        check("abort_rx_ready", {63'd0, rx_ready}, 64'd0);

        // Randomized frames
        for (int r = 0; r < 4; r++) begin
            mark();
            build_random(int'($urandom_range(1, 6)), 1'b0);
            pulse_start();
            send_frame(bit'($urandom_range(0, 1)), -1);
            compare($sformatf("rand%0d", r), 1, 1'b0);
        end

        // Reset asserted in the middle of a data word
        mark();
        build_random(2, 1'b0);
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(frame_q[i], 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_rx_ready", {63'd0, rx_ready}, 64'd0);
        end
        rx_valid = 1'b0;
        check("post_reset_no_write", 64'(obs_wr.size()), 64'd0);
        check("post_reset_cpu_hold", {63'd0, cpu_hold}, 64'd0);

        // Fresh load after reset
        mark();
        build_random(2, 1'b0);
        pulse_start();
        send_frame(1'b0, -1);
        compare("after_reset", 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
